// File: rtl/squarer_mod_reduce_pkg.sv
// Shared types and sizing helpers for the squarer modular-reduction stage.
package squarer_mod_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int steps_per_op(input int numbits, input int bits_per_cycle);
    return (2 * numbits) / bits_per_cycle;
  endfunction

  // Counter must hold 0 .. steps_per_op inclusive.
  function automatic int cnt_width(input int numbits, input int bits_per_cycle);
    return $clog2(steps_per_op(numbits, bits_per_cycle) + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(32, 1);

endpackage

// File: rtl/squarer_mod_reduce_step.sv
// One restoring shift-subtract step: r' = ((r << 1) | bit) reduced once by M.
module mod_shift_sub_step #(
  parameter int NUMBITS = 32
) (
  input  logic [NUMBITS:0]   r_i,
  input  logic               bit_i,
  input  logic [NUMBITS-1:0] m_i,
  output logic [NUMBITS:0]   r_o
);

  logic [NUMBITS+1:0] sh;
  logic [NUMBITS:0]   diff;
  logic               ge;

  // With r < M on entry the shifted value is below 2M, so one subtract restores the invariant.
  always_comb begin
    sh   = {r_i, bit_i};
    ge   = (sh >= {2'b00, m_i});
    diff = sh[NUMBITS:0] - {1'b0, m_i};
    r_o  = ge ? diff : sh[NUMBITS:0];
  end

endmodule

// File: rtl/squarer_mod_reduce.sv
// Sequential (square mod M) reduction behind valid/ready handshakes, BITS_PER_CYCLE steps per cycle.
module squarer_mod_reduce
  import squarer_mod_pkg::*;
#(
  parameter int NUMBITS        = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2*NUMBITS-1:0]   in_product,
  input  logic [NUMBITS-1:0]     in_modulus,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUMBITS-1:0]     out_rem,
  output logic                   out_err
);

  localparam int STEPS = steps_per_op(NUMBITS, BITS_PER_CYCLE);
  localparam int CNT_W = cnt_width(NUMBITS, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
      (((2 * NUMBITS) % BITS_PER_CYCLE) != 0)) begin : g_param_check
    $error("squarer_mod_reduce: BITS_PER_CYCLE must be 1, 2 or 4 and divide 2*NUMBITS");
  end

  state_t                 state_q, state_d;
  logic [2*NUMBITS-1:0]   prod_q, prod_d;
  logic [NUMBITS-1:0]     mod_q, mod_d;
  logic [NUMBITS:0]       r_q, r_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUMBITS-1:0]     rem_q, rem_d;
  logic                   err_q, err_d;

  wire  [NUMBITS:0]       chain [BITS_PER_CYCLE+1];

  assign chain[0] = r_q;

  // Product bits are consumed MSB-first; the product register shifts left each BUSY cycle.
  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    mod_shift_sub_step #(.NUMBITS(NUMBITS)) u_step (
      .r_i   (chain[g]),
      .bit_i (prod_q[2*NUMBITS-1-g]),
      .m_i   (mod_q),
      .r_o   (chain[g+1])
    );
  end

  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    mod_d     = mod_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          prod_d = in_product;
          mod_d  = in_modulus;
          r_d    = '0;
          cnt_d  = '0;
          if (in_modulus == '0) begin
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        prod_d = prod_q << BITS_PER_CYCLE;
        r_d    = chain[BITS_PER_CYCLE];
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          rem_d   = chain[BITS_PER_CYCLE][NUMBITS-1:0];
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prod_q  <= '0;
      mod_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prod_q  <= prod_d;
      mod_q   <= mod_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign out_rem = rem_q;
  assign out_err = err_q;

endmodule
